modred_pipe: RTL and testbench

//  Complete word-level Montgomery reduction pipeline for NTT-friendly primes q = qH*2^W_SIZE + 1.

---
 rtl/modred_pipe.sv | 182 ++++++++++++++++++
 tb/tb_modred_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/modred_pipe.sv
// modred_pipe: word-level Montgomery reduction pipeline for NTT-friendly
// primes q = qH*2^W_SIZE + 1. An input capture slot is followed by
// L = ceil(DATA_W/W_SIZE) three-slot reduction stages and a final
// conditional-subtraction slot. Result: C = T * 2^(-L*W_SIZE) mod q, in [0,q).
// qH, tag and valid travel with each sample, so moduli may be interleaved.
// Latency is 3*L+1 enabled cycles; en=0 freezes every register.
module modred_pipe #(
  parameter int DATA_W = 32,
  parameter int W_SIZE = 16,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [2*DATA_W-1:0]      in_t,
  input  logic [DATA_W-W_SIZE-1:0] in_qh,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_c,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  localparam int L    = (DATA_W + W_SIZE - 1) / W_SIZE;
  localparam int QH_W = DATA_W - W_SIZE;

  // Width of the T value on segment k: segment 0 is the raw product,
  // segment k>0 is the output of stage k, which is below q*(2^((L-k)*W)+2)
  // and so needs DATA_W+(L-k)*W_SIZE bits plus one guard bit.
  function automatic int segW(input int k);
    if (k == 0) return 2 * DATA_W;
    return DATA_W + (L - k) * W_SIZE + 1;
  endfunction

  // Bit offset of segment k inside the flat T bus.
  function automatic int segOff(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += segW(i);
    return s;
  endfunction

  localparam int FLAT_W = segOff(L + 1);
  localparam int V_OFF  = segOff(L);

  // All inter-stage T values live in one flat bus so each stage can carry
  // exactly its own width without padding bits left dangling.
  logic [FLAT_W-1:0] w_flatT;
  logic [QH_W-1:0]   w_qh  [0:L];
  logic [TAG_W-1:0]  w_tag [0:L];
  logic [L:0]        w_valid;
  logic [L-1:0]      w_stageBusy;

  logic [2*DATA_W-1:0] r_tIn;
  logic [QH_W-1:0]     r_qhIn;
  logic [TAG_W-1:0]    r_tagIn;
  logic                r_vIn;

  // Input capture valid bit: takes a new sample on each enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vIn <= 1'b0;
    end else if (en) begin
      r_vIn <= in_valid;
    end
  end

  // Input capture data: unreset, qualified by r_vIn, frozen while stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      r_tIn   <= in_t;
      r_qhIn  <= in_qh;
      r_tagIn <= in_tag;
    end
  end

  assign w_flatT[segW(0)-1:0] = r_tIn;
  assign w_qh[0]              = r_qhIn;
  assign w_tag[0]             = r_tagIn;
  assign w_valid[0]           = r_vIn;

  for (genvar k = 1; k <= L; k++) begin : gStage
    localparam int IW   = segW(k - 1);
    localparam int OW   = segW(k);
    localparam int IOFF = segOff(k - 1);
    localparam int OOFF = segOff(k);

    logic [IW-1:0]        w_tIn;
    logic [DATA_W-1:0]    w_prod;
    logic [IW-1:0]        r_t1;
    logic [W_SIZE-1:0]    r_m1;
    logic [IW-W_SIZE-1:0] r_th2;
    logic                 r_cy2;
    logic [DATA_W-1:0]    r_p2;
    logic [OW-1:0]        r_t3;
    logic [QH_W-1:0]      r_qh1, r_qh2, r_qh3;
    logic [TAG_W-1:0]     r_tag1, r_tag2, r_tag3;
    logic                 r_v1, r_v2, r_v3;

    assign w_tIn  = w_flatT[IOFF +: IW];
    // qH*M: a (DATA_W-W_SIZE) x W_SIZE product that fits DATA_W bits.
    assign w_prod = DATA_W'(r_qh1) * DATA_W'(r_m1);

    // Valid bits of the three slots shift together with the data.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
        r_v3 <= 1'b0;
      end else if (en) begin
        r_v1 <= w_valid[k-1];
        r_v2 <= r_v1;
        r_v3 <= r_v2;
      end
    end

    // S1 picks M = -TL mod 2^W, S2 splits T and forms qH*M, S3 adds
    // P + TH + CY which equals (T + M*q) / 2^W with nothing dropped.
    // CY is the carry out of TL + M, set exactly when TL is nonzero.
    always_ff @(posedge clk) begin
      if (en) begin
        r_t1   <= w_tIn;
        r_m1   <= W_SIZE'(0) - w_tIn[W_SIZE-1:0];
        r_qh1  <= w_qh[k-1];
        r_tag1 <= w_tag[k-1];
        r_th2  <= r_t1[IW-1:W_SIZE];
        r_cy2  <= |r_t1[W_SIZE-1:0];
        r_p2   <= w_prod;
        r_qh2  <= r_qh1;
        r_tag2 <= r_tag1;
        r_t3   <= OW'(r_p2) + OW'(r_th2) + OW'(r_cy2);
        r_qh3  <= r_qh2;
        r_tag3 <= r_tag2;
      end
    end

    assign w_flatT[OOFF +: OW] = r_t3;
    assign w_qh[k]             = r_qh3;
    assign w_tag[k]            = r_tag3;
    assign w_valid[k]          = r_v3;
    assign w_stageBusy[k-1]    = r_v1 | r_v2 | r_v3;
  end

  logic [DATA_W:0]   w_v;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] w_sub;
  logic              w_geq;
  logic              r_outValid;
  logic [DATA_W-1:0] r_outC;
  logic [TAG_W-1:0]  r_outTag;

  // The last stage leaves V < 2q, so one conditional subtract finishes it.
  // The modulus is rebuilt from the qH that travelled with this sample.
  // The difference is below 2^DATA_W, so the subtract needs no top bit.
  assign w_v   = w_flatT[V_OFF +: DATA_W+1];
  assign w_q   = {w_qh[L], W_SIZE'(1)};
  assign w_geq = (w_v >= {1'b0, w_q});
  assign w_sub = w_v[DATA_W-1:0] - w_q;

  // Correction slot: results only overwrite out_c/out_tag when valid,
  // so an empty pipeline keeps showing the last result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outC     <= '0;
      r_outTag   <= '0;
    end else if (en) begin
      r_outValid <= w_valid[L];
      if (w_valid[L]) begin
        r_outC   <= w_geq ? w_sub : w_v[DATA_W-1:0];
        r_outTag <= w_tag[L];
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_c     = r_outC;
  assign out_tag   = r_outTag;
  assign busy      = r_vIn | (|w_stageBusy) | r_outValid;

endmodule

// File: tb/tb_modred_pipe.sv
// tb_modred_pipe: bench for modred_pipe at DATA_W=32, W_SIZE=16, TAG_W=8.
// A reference model computes T * 2^-32 mod q by reducing T mod q and then
// halving modulo q 32 times, and schedules each result LAT enabled edges
// after acceptance. A negedge monitor compares every output each cycle;
// directed tests add hand-computed literal results and timing checks.
module tb_modred_pipe;

  localparam int LAT   = 7;
  localparam int RBITS = 32;
  localparam logic [15:0] QH_A = 16'hFFF0;
  localparam logic [15:0] QH_B = 16'h3001;
  localparam logic [63:0] Q_A  = 64'd4293918721;
  localparam logic [63:0] Q_B  = 64'd805371905;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [63:0] in_t;
  logic [15:0] in_qh;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic [31:0] out_c;
  logic [7:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] c;
    logic [7:0]  tag;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  int          enEdges = 0;
  logic        expVal  = 1'b0;
  logic [31:0] expC    = '0;
  logic [7:0]  expTag  = '0;
  logic [63:0] samp [64];

  modred_pipe #(.DATA_W(32), .W_SIZE(16), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .in_t(in_t), .in_qh(in_qh), .in_tag(in_tag),
    .out_valid(out_valid), .out_c(out_c), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Golden result: (t mod q) times 2^-1 mod q, applied RBITS times.
  function automatic logic [31:0] golden(input logic [63:0] t, input logic [15:0] qh);
    logic [63:0] q;
    logic [63:0] x;
    q = {32'd0, qh, 16'h0001};
    x = t % q;
    for (int i = 0; i < RBITS; i++) x = x[0] ? ((x + q) >> 1) : (x >> 1);
    return x[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] t, input logic [15:0] qh, input logic [7:0] tag);
    in_valid = valid;
    in_t     = t;
    in_qh    = qh;
    in_tag   = tag;
  endtask

  // Model: counts enabled edges, schedules each accepted sample LAT enabled
  // edges ahead, and holds everything while en is low.
  always @(posedge clk or posedge reset) begin : modelProc
    exp_t e;
    if (reset) begin
      expQ.delete();
      expVal = 1'b0;
      expC   = '0;
      expTag = '0;
    end else if (en) begin
      enEdges++;
      if (expQ.size() > 0 && expQ[0].due == enEdges) begin
        e      = expQ.pop_front();
        expVal = 1'b1;
        expC   = e.c;
        expTag = e.tag;
      end else begin
        expVal = 1'b0;
      end
      if (in_valid) expQ.push_back('{golden(in_t, in_qh), in_tag, enEdges + LAT});
    end
  end

  // Monitor: every output checked against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("outValid", out_valid, expVal);
    checkOutput("busy", busy, ((expQ.size() != 0) || expVal) ? 1 : 0);
    checkOutput("outC", out_c, expC);
    checkOutput("outTag", out_tag, expTag);
  end

  task automatic runDirected(input string name, input logic [63:0] t, input logic [15:0] qh,
                             input logic [7:0] tag, input logic [31:0] expected);
    int seen;
    seen = 0;
    @(negedge clk);
    en = 1'b1;
    applyStimulus(1'b1, t, qh, tag);
    @(posedge clk);
    #1 applyStimulus(1'b0, t, qh, tag);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        seen = i;
        break;
      end
    end
    checkOutput({name, "Latency"}, seen, LAT);
    checkOutput({name, "C"}, out_c, expected);
    checkOutput({name, "Tag"}, out_tag, tag);
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    en = 1'b1;
    applyStimulus(1'b0, 64'd0, QH_A, 8'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !expVal) break;
    end
    checkOutput({name, "DrainBusy"}, busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    int i;
    int lat;
    int leaked;
    reset = 1'b1;
    en    = 1'b1;
    applyStimulus(1'b0, 64'd0, QH_A, 8'd0);
    #12 reset = 1'b0;

    // Test 1: zero input, latency, tag echo, busy dropping afterwards
    @(negedge clk);
    applyStimulus(1'b1, 64'd0, QH_A, 8'hA5);
    @(posedge clk);
    #1 applyStimulus(1'b0, 64'd0, QH_A, 8'h00);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("t1Latency", lat, LAT);
    checkOutput("t1C", out_c, 0);
    checkOutput("t1Tag", out_tag, 8'hA5);
    @(posedge clk);
    #1;
    checkOutput("t1BusyDrop", busy, 0);
    checkOutput("t1ValidDrop", out_valid, 0);

    // Test 2: hand-computed values, including the V >= q correction path
    runDirected("identityA", 64'd1048575, QH_A, 8'd1, 32'd1);
    runDirected("inputQ", Q_A, QH_A, 8'd2, 32'd0);
    runDirected("fiveR", 64'd5 << 32, QH_A, 8'd3, 32'd5);
    runDirected("maxIn", (Q_A - 64'd1) << 32, QH_A, 8'd4, 32'd4293918720);
    runDirected("identityB", 64'd268107771, QH_B, 8'd5, 32'd1);

    // Test 3: 64 random in-contract samples at full rate
    for (int k = 0; k < 64; k++) samp[k] = {$urandom, $urandom} % (Q_A << 32);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, samp[k], QH_A, 8'(k));
    end
    drain("stream");

    // Test 4: same stream with en toggling pseudo-randomly
    i = 0;
    for (int guard = 0; guard < 2000 && i < 64; guard++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, samp[i], QH_A, 8'(i));
      if (en) i++;
    end
    checkOutput("stallAllSent", i, 64);
    drain("stall");

    // Test 5: alternating moduli every cycle
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) applyStimulus(1'b1, {$urandom, $urandom} % (Q_A << 32), QH_A, 8'(100 + k));
      else            applyStimulus(1'b1, {$urandom, $urandom} % (Q_B << 32), QH_B, 8'(100 + k));
    end
    drain("mixed");

    // Test 6: partial-cycle reset with 5 samples in flight
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, samp[k], QH_A, 8'(200 + k));
    end
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, QH_A, 8'd0);
    checkOutput("preResetBusy", busy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("resetValid", out_valid, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetC", out_c, 0);
    #1 reset = 1'b0;
    leaked = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) leaked++;
    end
    checkOutput("noLeak", leaked, 0);
    checkOutput("postResetBusy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
